// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared 8N1 line levels and receiver state encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx1_if.sv
// rtl/uart_rx1_if.sv - serial-in / byte-out bundle between line driver and receiver.
interface uart_rx1_if #(
  parameter int DATA_BITS = 8
);
  logic                 en;
  logic                 rxd;
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output en, rxd,
    input  dout, valid, frame_err, busy
  );

  modport slave (
    input  en, rxd,
    output dout, valid, frame_err, busy
  );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous input.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx1.sv
// rtl/uart_rx1.sv - 8N1 serial receiver sampling on an oversample tick enable.
module uart_rx1
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16
) (
  input logic        clk,
  input logic        rst_,
  uart_rx1_if.slave  bus
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  rx_state_t            r_state, w_state_nxt;
  logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_dout, w_dout_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_frame_err, w_frame_err_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_rxs;

  sync2 #(.RST_VAL(LINE_IDLE)) u_sync_rxd (
    .clk  (clk),
    .rst_ (rst_),
    .i_d  (bus.rxd),
    .o_q  (w_rxs)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_dout      <= w_dout_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Everything holds between ticks except the two flag pulses, which self-clear.
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick_cnt;
    w_bit_nxt       = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_dout_nxt      = r_dout;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_busy_nxt      = r_busy;

    if (bus.en) begin
      case (r_state)
        S_IDLE: begin
          if (w_rxs == START_LVL) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
            w_busy_nxt  = 1'b1;
          end
        end
        S_START: begin
          if (r_tick_cnt == TICK_HALF) begin
            w_tick_nxt = '0;
            if (w_rxs == START_LVL) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        S_DATA: begin
          if (r_tick_cnt == TICK_FULL) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + BIT_ONE;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        S_STOP: begin
          if (r_tick_cnt == TICK_FULL) begin
            w_tick_nxt = '0;
            if (w_rxs == STOP_LVL) begin
              w_dout_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = S_BREAK;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        S_BREAK: begin
          // A held-low line must go high before a new start can be seen.
          if (w_rxs == LINE_IDLE) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign bus.dout      = r_dout;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_rx1.sv
// tb/tb_uart_rx1.sv - directed-vector bench for uart_rx1 (OVS=16, en every 4 clks, 64-clk bits).
module tb_uart_rx1;

  localparam int BIT_CLKS = 64;

  logic clk;
  logic rst_;
  logic en_gate;
  int   errors;
  int   checks;

  int          valid_cnt;
  int          ferr_cnt;
  int          valid_wide;
  int          ferr_wide;
  int          busy_run;
  int          busy_max;
  logic        prev_valid;
  logic        prev_ferr;
  logic [7:0]  rx_q[$];

  uart_rx1_if #(.DATA_BITS(8)) bus ();

  uart_rx1 #(.DATA_BITS(8), .OVS(16)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator pauses its phase while gated so bit timing stays fixed in en ticks.
  initial begin
    int phase;
    phase = 0;
    bus.en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (en_gate) begin
        bus.en = (phase == 3);
        phase  = (phase + 1) % 4;
      end else begin
        bus.en = 1'b0;
      end
    end
  end

  initial begin
    valid_cnt  = 0;
    ferr_cnt   = 0;
    valid_wide = 0;
    ferr_wide  = 0;
    busy_run   = 0;
    busy_max   = 0;
    prev_valid = 1'b0;
    prev_ferr  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.valid) begin
        valid_cnt++;
        rx_q.push_back(bus.dout);
      end
      if (bus.frame_err) ferr_cnt++;
      if (bus.valid && prev_valid) valid_wide++;
      if (bus.frame_err && prev_ferr) ferr_wide++;
      prev_valid = bus.valid;
      prev_ferr  = bus.frame_err;
      if (bus.busy) begin
        busy_run++;
      end else begin
        if (busy_run > busy_max) busy_max = busy_run;
        busy_run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    bus.rxd = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
    hold(stop, BIT_CLKS);
  endtask

  task automatic clear_stats();
    valid_cnt = 0;
    ferr_cnt  = 0;
    busy_max  = 0;
    rx_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    errors  = 0;
    checks  = 0;
    en_gate = 1'b1;
    bus.rxd = 1'b1;
    rst_    = 1'b0;
    repeat (10) @(negedge clk);

    check("reset_dout", 32'(bus.dout), 32'h00);
    check("reset_valid", 32'(bus.valid), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);

    rst_ = 1'b1;
    hold(1'b1, BIT_CLKS);
    clear_stats();

    // Single frame 0xA5
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 2 * BIT_CLKS);
    check("a5_valid_count", 32'(valid_cnt), 32'd1);
    check("a5_rx_byte", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'hA5);
    check("a5_dout", 32'(bus.dout), 32'hA5);
    check("a5_frame_err_count", 32'(ferr_cnt), 32'd0);
    check("a5_busy_after", 32'(bus.busy), 32'h0);

    // Back-to-back 0x00 and 0xFF with no idle gap
    clear_stats();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 2 * BIT_CLKS);
    check("b2b_valid_count", 32'(valid_cnt), 32'd2);
    check("b2b_first", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h55), 32'h00);
    check("b2b_second", 32'(rx_q.size() > 1 ? rx_q[1] : 8'h55), 32'hFF);
    check("b2b_dout", 32'(bus.dout), 32'hFF);

    // Start-bit glitch of 4 en ticks
    clear_stats();
    hold(1'b0, 16);
    hold(1'b1, 3 * BIT_CLKS);
    check("glitch_valid_count", 32'(valid_cnt), 32'd0);
    check("glitch_frame_err_count", 32'(ferr_cnt), 32'd0);
    check("glitch_busy_after", 32'(bus.busy), 32'h0);
    check("glitch_busy_seen", 32'(busy_max > 0), 32'h1);
    check("glitch_busy_short", 32'(busy_max < 36), 32'h1);

    // Stop bit low followed by a break, then a good frame
    clear_stats();
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 3 * BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    check("brk_frame_err_count", 32'(ferr_cnt), 32'd1);
    check("brk_valid_count", 32'(valid_cnt), 32'd0);
    check("brk_dout_kept", 32'(bus.dout), 32'hFF);
    check("brk_busy_after", 32'(bus.busy), 32'h0);
    send_frame(8'h81, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("after_brk_valid_count", 32'(valid_cnt), 32'd1);
    check("after_brk_dout", 32'(bus.dout), 32'h81);

    // Reset in the middle of 0x5A data bits
    clear_stats();
    d = 8'h5A;
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(d[i], BIT_CLKS);
    hold(d[4], BIT_CLKS / 2);
    rst_ = 1'b0;
    hold(1'b1, 8);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    check("rst_mid_dout", 32'(bus.dout), 32'h00);
    rst_ = 1'b1;
    hold(1'b1, 2 * BIT_CLKS);
    check("rst_mid_no_valid", 32'(valid_cnt), 32'd0);
    check("rst_mid_no_ferr", 32'(ferr_cnt), 32'd0);
    send_frame(8'hC3, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("post_rst_valid_count", 32'(valid_cnt), 32'd1);
    check("post_rst_dout", 32'(bus.dout), 32'hC3);

    // en gated off for 200 clks in the middle of data bit 4 of 0x69
    clear_stats();
    d = 8'h69;
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(d[i], BIT_CLKS);
    hold(d[4], BIT_CLKS / 2);
    en_gate = 1'b0;
    hold(d[4], 200);
    check("gate_busy_frozen", 32'(bus.busy), 32'h1);
    check("gate_no_valid", 32'(valid_cnt), 32'd0);
    en_gate = 1'b1;
    hold(d[4], BIT_CLKS / 2);
    for (int i = 5; i < 8; i++) hold(d[i], BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    check("gate_valid_count", 32'(valid_cnt), 32'd1);
    check("gate_dout", 32'(bus.dout), 32'h69);
    check("gate_frame_err_count", 32'(ferr_cnt), 32'd0);

    check("valid_one_cycle", 32'(valid_wide), 32'd0);
    check("frame_err_one_cycle", 32'(ferr_wide), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
